clint_timer: RTL and testbench
==============================

// Module: clint_timer
// PURPOSE
//  Core-local interrupt source: the producer side of the machine interrupt-pending bits.
//  Holds a 64-bit mtime counter, a 64-bit mtimecmp register, a software-interrupt bit and an external-IRQ synchroniser.
//  Drives MSIP/MTIP/MEIP positions of irq_mip into the CSR mip register that feeds the interrupt controller.
//  CPU programs it through a simple memory-mapped 32-bit request/ready bus.
// PARAMETERS
//  ADDR_W    8  width of bus_addr (byte address, word aligned)
//  PRESCALE  4  mtime tick period in clk cycles (only used with CLINT_PRESCALER_EN; must be >=1)
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  reset      in   1   synchronous, active-low reset (reset==0 resets on the next clk edge)
//  bus_req    in   1   request strobe, one transaction per cycle
//  bus_we     in   1   1=write, 0=read; sampled with bus_req
//  bus_addr   in   ADDR_W  byte address; bits [1:0] ignored
//  bus_wdata  in   32  write data
//  bus_ready  out  1   response strobe, exactly one per accepted request
//  bus_rdata  out  32  read data, valid only while bus_ready=1, else 0
//  bus_err    out  1   unmapped address, valid with bus_ready
//  ext_irq    in   1   asynchronous level external interrupt
//  irq_mip    out  32  bit3=MSIP, bit7=MTIP, bit11=MEIP, all other bits 0
// BEHAVIOUR
//  Reset (reset==0): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, sync flops=0, prescale cnt=0,
//   bus_ready=0, bus_rdata=0, bus_err=0, irq_mip=0. Reset mid-transaction drops the response.
//  Register map (addr[ADDR_W-1:2]<<2): 0x00 MSIP (bit0 RW, others RAZ/WI); 0x08 MTIMECMP[31:0];
//   0x0C MTIMECMP[63:32]; 0x10 MTIME[31:0]; 0x14 MTIME[63:32]. Any other address: read 0, write ignored, bus_err=1.
//  Bus: every cycle with bus_req=1 is accepted (no backpressure); bus_ready pulses exactly 1 cycle later,
//   fully pipelined (back-to-back requests give back-to-back ready). Reads return register value
//   at the request cycle (pre-write, pre-tick). Writes take effect at the request-cycle edge.
//  mtime: increments by 1 per tick; wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
//   Tick = every cycle (macro off) or every PRESCALE cycles (macro on).
//   Bus write to either MTIME word: written word gets wdata, other word holds, increment suppressed that cycle.
//  MTIP: registered, irq_mip[7] = (mtime >= mtimecmp) evaluated on the values after the previous edge,
//   i.e. asserts 1 cycle after the compare becomes true; unsigned 64-bit compare; level, cleared only by
//   raising mtimecmp or lowering mtime. Reset value of mtimecmp keeps MTIP low until reprogrammed.
//  MSIP: irq_mip[3] = msip register directly (visible the cycle after the write edge).
//  MEIP: ext_irq through 2-flop synchroniser; irq_mip[11] = second flop (2-cycle latency), level, no latch.
//  Simultaneous: bus write to mtimecmp and compare in same cycle -> next MTIP uses new mtimecmp one cycle later (no glitch hold).
// CONFIGURATION
//  CLINT_PRESCALER_EN defined: prescale counter 0..PRESCALE-1, tick when counter==PRESCALE-1 then counter->0;
//   a bus write to MTIME also clears the counter. PRESCALE=1 behaves as macro off.
//  Not defined: no prescale counter, mtime ticks every clk cycle; PRESCALE ignored.
// TESTING
//  Reset: hold reset=0 3 cycles -> irq_mip=0, read 0x0C returns 32'hFFFF_FFFF, read 0x10 right after release returns 0..2.
//  Timer fire (macro off): write MTIME lo=0, MTIMECMP hi=0, lo=20 -> irq_mip[7] rises exactly when mtime reaches 21 value-cycle+1; write MTIMECMP lo=FFFF_FFFF -> MTIP drops next cycle.
//  Wrap: write MTIME hi=FFFF_FFFF, lo=FFFF_FFFE -> read hi/lo after 3 cycles gives 0/small value; MTIP stays 0 with mtimecmp=max until wrap then drops.
//  MSIP: write 0x00=1 -> irq_mip[3]=1; read 0x00=1; write 0x00=32'hFFFF_FFFE -> irq_mip[3]=0, read 0.
//  External: ext_irq 0->1 -> irq_mip[11]=1 after exactly 2 edges; 1->0 -> clears after 2 edges.
//  Bus: read 0x20 -> bus_ready=1, bus_err=1, rdata=0; 4 back-to-back requests -> 4 consecutive ready pulses.
//  Prescaler (macro on, PRESCALE=4): write MTIME lo=0 -> after 16 cycles read 0x10 returns 4.

Source files
------------

// File: rtl/clint_timer.sv
// clint_timer: core-local interrupt source feeding the MSIP/MTIP/MEIP bits of mip.
//
// Holds a 64-bit free-running mtime, a 64-bit mtimecmp, a software-interrupt bit and a
// two-flop synchroniser for the external interrupt line. Programmed over a 32-bit
// request/ready bus with a fixed one-cycle response latency and no backpressure.
//
// Register map (word-aligned byte address, addr[1:0] ignored):
//   0x00 MSIP (bit0 RW, others read 0), 0x08/0x0C MTIMECMP lo/hi, 0x10/0x14 MTIME lo/hi.
//   Anything else reads 0, ignores writes and responds with bus_err.
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      synchronous active-low reset
//   bus_req    request strobe (one transaction per cycle)
//   bus_we     1 = write, 0 = read
//   bus_addr   byte address
//   bus_wdata  write data
//   bus_ready  response strobe, one cycle after each request
//   bus_rdata  read data (0 unless responding to a read)
//   bus_err    unmapped address, valid with bus_ready
//   ext_irq    asynchronous level external interrupt
//   irq_mip    bit3 MSIP, bit7 MTIP, bit11 MEIP, all other bits 0
//
// Build option: define CLINT_PRESCALER_EN to tick mtime once every PRESCALE cycles instead
// of every cycle.

module clint_timer #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned PRESCALE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic              bus_ready,
  output logic [31:0]       bus_rdata,
  output logic              bus_err,
  input  logic              ext_irq,
  output logic [31:0]       irq_mip
);

  localparam logic [ADDR_W-1:0] AddrMsip    = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] AddrCmpLo   = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] AddrCmpHi   = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] AddrTimeLo  = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] AddrTimeHi  = ADDR_W'(8'h14);

  logic [63:0]       mtime_q, mtime_d;
  logic [63:0]       mtimecmp_q, mtimecmp_d;
  logic              msip_q, msip_d;
  logic              mtip_q;
  logic [1:0]        sync_q;
  logic              ready_q, err_q;
  logic [31:0]       rdata_q;

  logic [ADDR_W-1:0] addr_word;
  logic              mapped;
  logic [31:0]       rd_val;
  logic              wr_en;
  logic              wr_time_lo, wr_time_hi;
  logic              tick;
  logic              unused_addr_bits;

  assign addr_word        = {bus_addr[ADDR_W-1:2], 2'b00};
  assign unused_addr_bits = ^bus_addr[1:0];
  assign wr_en            = bus_req & bus_we;
  assign wr_time_lo       = wr_en & (addr_word == AddrTimeLo);
  assign wr_time_hi       = wr_en & (addr_word == AddrTimeHi);

  // Read mux samples the registers as they stand in the request cycle (pre-write, pre-tick).
  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    case (addr_word)
      AddrMsip:   rd_val = {31'b0, msip_q};
      AddrCmpLo:  rd_val = mtimecmp_q[31:0];
      AddrCmpHi:  rd_val = mtimecmp_q[63:32];
      AddrTimeLo: rd_val = mtime_q[31:0];
      AddrTimeHi: rd_val = mtime_q[63:32];
      default:    mapped = 1'b0;
    endcase
  end

`ifdef CLINT_PRESCALER_EN
  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CntW'(PRESCALE - 1));
    cnt_d = cnt_q + CntW'(1);
    // A software write to mtime restarts the tick period.
    if (tick || wr_time_lo || wr_time_hi) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unsigned UnusedPrescale = PRESCALE;

  assign tick = 1'b1;
`endif

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    // A write to either mtime word suppresses that cycle's increment.
    if (wr_time_lo) begin
      mtime_d[31:0] = bus_wdata;
    end else if (wr_time_hi) begin
      mtime_d[63:32] = bus_wdata;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (wr_en && (addr_word == AddrCmpLo)) begin
      mtimecmp_d[31:0] = bus_wdata;
    end
    if (wr_en && (addr_word == AddrCmpHi)) begin
      mtimecmp_d[63:32] = bus_wdata;
    end
    if (wr_en && (addr_word == AddrMsip)) begin
      msip_d = bus_wdata[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      sync_q     <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      // Compare uses the pre-edge values, so MTIP trails the compare by one cycle.
      mtip_q     <= (mtime_q >= mtimecmp_q);
      sync_q     <= {sync_q[0], ext_irq};
      ready_q    <= bus_req;
      err_q      <= bus_req & ~mapped;
      rdata_q    <= (bus_req && !bus_we) ? rd_val : 32'd0;
    end
  end

  assign bus_ready = ready_q;
  assign bus_rdata = rdata_q;
  assign bus_err   = err_q;

  always_comb begin
    irq_mip     = '0;
    irq_mip[3]  = msip_q;
    irq_mip[7]  = mtip_q;
    irq_mip[11] = sync_q[1];
  end

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: directed bus sequences with literal expectations, plus a
// cycle-by-cycle reference model of the register file, timer, interrupt bits and bus
// responses that is compared against every DUT output on each falling edge.

module tb_clint_timer;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned PRESCALE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [7:0]  bus_addr = 8'h00;
  logic [31:0] bus_wdata = 32'h0;
  logic        ext_irq = 1'b0;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic [31:0] irq_mip;

  clint_timer #(
    .ADDR_W   (ADDR_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata),
    .bus_err   (bus_err),
    .ext_irq   (ext_irq),
    .irq_mip   (irq_mip)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [63:0] m_time;
  logic [63:0] m_cmp;
  logic        m_msip;
  logic        m_mtip;
  logic        m_ext_d1;   // ext_irq as sampled one edge ago
  logic        m_ext_d2;   // ext_irq as sampled two edges ago
  logic        m_rdy;
  logic        m_err;
  logic [31:0] m_rdata;
  int unsigned m_cnt;
  bit          m_live = 1'b0;

  function automatic bit m_mapped(logic [7:0] a);
    logic [7:0] w;
    w = {a[7:2], 2'b00};
    return (w == 8'h00) || (w == 8'h08) || (w == 8'h0C) || (w == 8'h10) || (w == 8'h14);
  endfunction

  function automatic logic [31:0] m_read(logic [7:0] a);
    logic [7:0] w;
    w = {a[7:2], 2'b00};
    case (w)
      8'h00:   return {31'b0, m_msip};
      8'h08:   return m_cmp[31:0];
      8'h0C:   return m_cmp[63:32];
      8'h10:   return m_time[31:0];
      8'h14:   return m_time[63:32];
      default: return 32'h0;
    endcase
  endfunction

  initial begin : model
    logic [7:0] w;
    bit         wr, wr_time, tk;
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_time   = 64'h0;
        m_cmp    = '1;
        m_msip   = 1'b0;
        m_mtip   = 1'b0;
        m_ext_d1 = 1'b0;
        m_ext_d2 = 1'b0;
        m_rdy    = 1'b0;
        m_err    = 1'b0;
        m_rdata  = 32'h0;
        m_cnt    = 0;
        m_live   = 1'b1;
      end else begin
        w       = {bus_addr[7:2], 2'b00};
        wr      = bus_req && bus_we;
        wr_time = wr && (w == 8'h10 || w == 8'h14);
        m_mtip  = (m_time >= m_cmp);
        m_rdy   = bus_req;
        m_err   = bus_req && !m_mapped(bus_addr);
        m_rdata = (bus_req && !bus_we) ? m_read(bus_addr) : 32'h0;
        m_ext_d2 = m_ext_d1;
        m_ext_d1 = ext_irq;
`ifdef CLINT_PRESCALER_EN
        tk    = (m_cnt == PRESCALE - 1);
        m_cnt = (wr_time || tk) ? 0 : m_cnt + 1;
`else
        tk = 1'b1;
`endif
        if (wr && w == 8'h00) m_msip = bus_wdata[0];
        if (wr && w == 8'h08) m_cmp[31:0] = bus_wdata;
        if (wr && w == 8'h0C) m_cmp[63:32] = bus_wdata;
        if (wr && w == 8'h10) m_time[31:0] = bus_wdata;
        else if (wr && w == 8'h14) m_time[63:32] = bus_wdata;
        else if (tk) m_time = m_time + 64'd1;
      end
    end
  end

  initial begin : compare
    logic [31:0] exp_mip;
    forever begin
      @(negedge clk);
      if (m_live) begin
        exp_mip     = 32'h0;
        exp_mip[3]  = m_msip;
        exp_mip[7]  = m_mtip;
        exp_mip[11] = m_ext_d2;
        check("model_bus_ready", 64'(bus_ready), 64'(m_rdy));
        check("model_bus_err", 64'(bus_err), 64'(m_err));
        check("model_bus_rdata", 64'(bus_rdata), 64'(m_rdata));
        check("model_irq_mip", 64'(irq_mip), 64'(exp_mip));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(logic [7:0] a, logic [31:0] d);
    bus_req   = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = a;
    bus_wdata = d;
    @(posedge clk);
    #2;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
  endtask

  task automatic rd(logic [7:0] a, output logic [31:0] d, output logic e, output logic r);
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = a;
    @(posedge clk);
    #2;
    d = bus_rdata;
    e = bus_err;
    r = bus_ready;
    bus_req = 1'b0;
  endtask

  logic [31:0] d;
  logic        e, r;
  logic [7:0]  b2b_addr [4];

  initial begin : main
    b2b_addr = '{8'h00, 8'h08, 8'h0C, 8'h14};

    // Reset held for three edges.
    reset = 1'b0;
    cyc(3);
    check("reset_irq_mip", 64'(irq_mip), 64'h0);
    check("reset_ready", 64'(bus_ready), 64'h0);
    reset = 1'b1;
    rd(8'h10, d, e, r);
    check("reset_mtime_lo_small", 64'(d <= 32'd2), 64'h1);
    rd(8'h0C, d, e, r);
    check("reset_cmp_hi", 64'(d), 64'hFFFF_FFFF);

    // Timer fire: mtime reset to 0, compare at 20.
    wr(8'h10, 32'h0);
    wr(8'h0C, 32'h0);
    wr(8'h08, 32'd20);
    cyc(18);
`ifndef CLINT_PRESCALER_EN
    check("mtip_before_fire", 64'(irq_mip[7]), 64'h0);
`endif
    cyc(1);
`ifndef CLINT_PRESCALER_EN
    check("mtip_fire_at_21", 64'(irq_mip[7]), 64'h1);
`endif
    cyc(3);
    wr(8'h08, 32'hFFFF_FFFF);
`ifndef CLINT_PRESCALER_EN
    check("mtip_hold_on_cmp_write", 64'(irq_mip[7]), 64'h1);
`endif
    cyc(1);
    check("mtip_drop_after_cmp_raise", 64'(irq_mip[7]), 64'h0);

    // Wrap: compare at max, mtime just below max.
    wr(8'h0C, 32'hFFFF_FFFF);
    wr(8'h14, 32'hFFFF_FFFF);
    wr(8'h10, 32'hFFFF_FFFE);
`ifndef CLINT_PRESCALER_EN
    check("wrap_mtip_low_0", 64'(irq_mip[7]), 64'h0);
    cyc(1);
    check("wrap_mtip_low_1", 64'(irq_mip[7]), 64'h0);
    cyc(1);
    check("wrap_mtip_at_max", 64'(irq_mip[7]), 64'h1);
    cyc(1);
    check("wrap_mtip_drop", 64'(irq_mip[7]), 64'h0);
    rd(8'h14, d, e, r);
    check("wrap_mtime_hi", 64'(d), 64'h0);
    rd(8'h10, d, e, r);
    check("wrap_mtime_lo", 64'(d), 64'd2);
`else
    cyc(3 * PRESCALE + 4);
`endif

    // Software interrupt.
    wr(8'h00, 32'h1);
    check("msip_set", 64'(irq_mip[3]), 64'h1);
    rd(8'h00, d, e, r);
    check("msip_read_1", 64'(d), 64'h1);
    wr(8'h00, 32'hFFFF_FFFE);
    check("msip_clear", 64'(irq_mip[3]), 64'h0);
    rd(8'h00, d, e, r);
    check("msip_read_0", 64'(d), 64'h0);

    // External interrupt through the synchroniser.
    ext_irq = 1'b1;
    cyc(1);
    check("meip_rise_edge1", 64'(irq_mip[11]), 64'h0);
    cyc(1);
    check("meip_rise_edge2", 64'(irq_mip[11]), 64'h1);
    ext_irq = 1'b0;
    cyc(1);
    check("meip_fall_edge1", 64'(irq_mip[11]), 64'h1);
    cyc(1);
    check("meip_fall_edge2", 64'(irq_mip[11]), 64'h0);

    // Unmapped address.
    rd(8'h20, d, e, r);
    check("unmapped_ready", 64'(r), 64'h1);
    check("unmapped_err", 64'(e), 64'h1);
    check("unmapped_rdata", 64'(d), 64'h0);
    wr(8'h18, 32'h1234_5678);
    check("unmapped_wr_err", 64'(bus_err), 64'h1);

    // Four back-to-back reads.
    bus_req = 1'b1;
    bus_we  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_addr = b2b_addr[i];
      @(posedge clk);
      #2;
      check("b2b_ready", 64'(bus_ready), 64'h1);
      if (i == 2) check("b2b_cmp_hi", 64'(bus_rdata), 64'hFFFF_FFFF);
    end
    bus_req = 1'b0;
    cyc(1);
    check("b2b_ready_end", 64'(bus_ready), 64'h0);

`ifdef CLINT_PRESCALER_EN
    wr(8'h10, 32'h0);
    cyc(16);
    rd(8'h10, d, e, r);
    check("prescale_mtime_lo", 64'(d), 64'd4);
`endif

    // Reset asserted in the request cycle drops the response.
    bus_req  = 1'b1;
    bus_addr = 8'h10;
    reset    = 1'b0;
    cyc(1);
    check("reset_drops_response", 64'(bus_ready), 64'h0);
    bus_req = 1'b0;
    reset   = 1'b1;
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
